// File: rtl/wb_commit_unit_pkg.sv
// Shared writeback types: retire-queue entry, half-write encodings and head FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        HALF_FULL    = 2'b00,
        HALF_LOW     = 2'b01,
        HALF_HIGH    = 2'b10,
        HALF_ILLEGAL = 2'b11
    } half_e;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    typedef struct packed {
        logic [3:0]  reg_dst;
        logic [31:0] alu_result;
        logic        wb_sel;
        half_e       half;
    } wb_entry_t;

    typedef enum logic {
        HEAD_IDLE,
        HEAD_WAIT_MEM
    } head_state_e;

endpackage

// File: rtl/wb_commit_unit_if.sv
// Retire-side handshake, load-data return and register-file write port of the commit unit.
interface wb_commit_unit_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_reg_wr;
    logic             in_wb_sel;
    logic [3:0]       in_reg_dst;
    logic [31:0]      in_alu_result;
    logic [1:0]       in_half;
    logic             mem_rdata_valid;
    logic [31:0]      mem_rdata;
    logic             wr;
    logic [3:0]       wr_dst;
    logic [31:0]      wr_data;
    logic             high;
    logic             low;
    logic             stall;
    logic [CNT_W-1:0] retired_cnt;
    logic             rdata_ovf;

    modport slave (
        input  in_valid, in_reg_wr, in_wb_sel, in_reg_dst, in_alu_result, in_half,
        input  mem_rdata_valid, mem_rdata,
        output in_ready, stall, wr, wr_dst, wr_data, high, low, retired_cnt, rdata_ovf
    );

    modport master (
        output in_valid, in_reg_wr, in_wb_sel, in_reg_dst, in_alu_result, in_half,
        output mem_rdata_valid, mem_rdata,
        input  in_ready, stall, wr, wr_dst, wr_data, high, low, retired_cnt, rdata_ovf
    );
endinterface

// File: rtl/wb_retire_fifo.sv
// In-order retire queue of wb_entry_t with combinational head read.
module wb_retire_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // NOTE: storage is not reset; only pointers and count decide which slots hold live entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit stage: queues retiring results, pairs loads with returning data, drives the register-file write port.
module wb_commit_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    wb_commit_unit_if.slave  bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t    in_entry;
    wb_entry_t    head;
    logic         push;
    logic         full;
    logic         empty;
    logic [AW:0]  count;
    head_state_e  state;
    head_state_e  state_next;
    logic         commit;
    logic [31:0]  commit_data;
    logic         hold_valid;
    logic [31:0]  hold_data;
    logic         head_is_mem;
    logic         hold_take;
    logic         bypass;

    assign in_entry = '{reg_dst:    bus.in_reg_dst,
                        alu_result: bus.in_alu_result,
                        wb_sel:     bus.in_wb_sel,
                        half:       half_e'(bus.in_half)};

    // Readiness depends on the registered count only, so a same-cycle pop never frees a slot.
    assign bus.in_ready = (count < FULL_CNT);
    assign bus.stall    = full;
    assign push         = bus.in_valid && bus.in_ready && bus.in_reg_wr;

    wb_retire_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_entry),
        .pop   (commit),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_is_mem = (head.wb_sel == WB_SEL_MEM);
    assign hold_take   = commit && head_is_mem && hold_valid;
    assign bypass      = commit && head_is_mem && !hold_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= HEAD_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        commit_data = head.alu_result;
        case (state)
            HEAD_IDLE: begin
                if (!empty) begin
                    if (!head_is_mem || hold_valid || bus.mem_rdata_valid) commit = 1'b1;
                    else                                                  state_next = HEAD_WAIT_MEM;
                end
            end
            HEAD_WAIT_MEM: begin
                if (hold_valid || bus.mem_rdata_valid) begin
                    commit     = 1'b1;
                    state_next = HEAD_IDLE;
                end
            end
        endcase
        // Held data is older than anything arriving now, so it goes first.
        if (head_is_mem) commit_data = hold_valid ? hold_data : bus.mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid    <= 1'b0;
            bus.rdata_ovf <= 1'b0;
        end else if (bus.mem_rdata_valid && !bypass) begin
            if (!hold_valid || hold_take) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.mem_rdata;
            end else begin
                bus.rdata_ovf <= 1'b1;
            end
        end else if (hold_take) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr          <= 1'b0;
            bus.wr_dst      <= '0;
            bus.wr_data     <= '0;
            bus.high        <= 1'b0;
            bus.low         <= 1'b0;
            bus.retired_cnt <= '0;
        end else begin
            bus.wr   <= commit;
            bus.high <= commit && (head.half == HALF_HIGH);
            bus.low  <= commit && (head.half == HALF_LOW);
            if (commit) begin
                bus.wr_dst      <= head.reg_dst;
                bus.wr_data     <= commit_data;
                bus.retired_cnt <= bus.retired_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed vector table, corner sequences, randomized run against a queue model.
module tb_wb_commit_unit;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic        rst;
        logic        v;
        logic        reg_wr;
        logic        sel;
        logic [3:0]  dst;
        logic [31:0] res;
        logic [1:0]  half;
        logic        mv;
        logic [31:0] md;
    } in_t;

    typedef struct {
        in_t         in;
        logic        wr;
        logic [3:0]  dst;
        logic [31:0] data;
        logic        hi;
        logic        lo;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]  dst;
        logic [31:0] res;
        logic        sel;
        logic [1:0]  half;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_commit_unit_if #(.CNT_W(CNT_W)) bus ();

    wb_commit_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    ent_t        q[$];
    logic [31:0] hq[$];
    logic        m_wr, m_hi, m_lo, m_ovf;
    logic [3:0]  m_dst;
    logic [31:0] m_data;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(logic v, logic sel, logic [3:0] dst, logic [31:0] res,
                               logic [1:0] half, logic mv, logic [31:0] md);
        in_t s;
        s.rst = 1'b0; s.v = v; s.reg_wr = 1'b1; s.sel = sel; s.dst = dst;
        s.res = res; s.half = half; s.mv = mv; s.md = md;
        return s;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 1'b0, 4'd0, 32'd0, 2'b00, 1'b0, 32'd0);
    endfunction

    task automatic model_step(input in_t s);
        bit   rdy, com, used_mem;
        ent_t e;
        if (s.rst) begin
            q.delete(); hq.delete();
            m_wr = 0; m_hi = 0; m_lo = 0; m_ovf = 0; m_dst = 0; m_data = 0; m_cnt = 0;
            return;
        end
        rdy      = q.size() < DEPTH;
        com      = (q.size() > 0) && (q[0].sel == 1'b0 || hq.size() > 0 || s.mv);
        used_mem = 0;
        if (com) begin
            e     = q.pop_front();
            m_wr  = 1;
            m_dst = e.dst;
            m_hi  = (e.half == 2'b10);
            m_lo  = (e.half == 2'b01);
            if (e.sel == 1'b0)        m_data = e.res;
            else if (hq.size() > 0)   m_data = hq.pop_front();
            else begin                m_data = s.md; used_mem = 1; end
            m_cnt++;
        end else begin
            m_wr = 0; m_hi = 0; m_lo = 0;
        end
        if (s.mv && !used_mem) begin
            if (hq.size() == 0) hq.push_back(s.md);
            else                m_ovf = 1;
        end
        if (s.v && rdy && s.reg_wr) begin
            e.dst = s.dst; e.res = s.res; e.sel = s.sel; e.half = s.half;
            q.push_back(e);
        end
    endtask

    task automatic cycle(input in_t s);
        rst                 = s.rst;
        bus.in_valid        = s.v;
        bus.in_reg_wr       = s.reg_wr;
        bus.in_wb_sel       = s.sel;
        bus.in_reg_dst      = s.dst;
        bus.in_alu_result   = s.res;
        bus.in_half         = s.half;
        bus.mem_rdata_valid = s.mv;
        bus.mem_rdata       = s.md;
        model_step(s);
        @(posedge clk);
        #1;
        check("wr",          {31'd0, bus.wr},          {31'd0, m_wr});
        check("wr_dst",      {28'd0, bus.wr_dst},      {28'd0, m_dst});
        check("wr_data",     bus.wr_data,              m_data);
        check("high",        {31'd0, bus.high},        {31'd0, m_hi});
        check("low",         {31'd0, bus.low},         {31'd0, m_lo});
        check("retired_cnt", {16'd0, bus.retired_cnt}, {16'd0, m_cnt});
        check("rdata_ovf",   {31'd0, bus.rdata_ovf},   {31'd0, m_ovf});
        check("in_ready",    {31'd0, bus.in_ready},    {31'd0, (q.size() < DEPTH)});
        check("stall",       {31'd0, bus.stall},       {31'd0, (q.size() >= DEPTH)});
    endtask

    vec_t tbl[17];

    task automatic set_vec(input int i, input in_t s, input logic wr, input logic [3:0] dst,
                           input logic [31:0] data, input logic hi, input logic lo, input logic [15:0] cnt);
        tbl[i].in = s; tbl[i].wr = wr; tbl[i].dst = dst; tbl[i].data = data;
        tbl[i].hi = hi; tbl[i].lo = lo; tbl[i].cnt = cnt;
    endtask

    in_t rs;

    initial begin
        // ALU stream, load wait with late data, upper-half write, illegal half encoding
        set_vec(0,  mk(1, 0, 4'd3, 32'h11, 2'b00, 0, 0),               0, 4'd0, 32'h0,        0, 0, 16'd0);
        set_vec(1,  mk(1, 0, 4'd4, 32'h22, 2'b00, 0, 0),               1, 4'd3, 32'h11,       0, 0, 16'd1);
        set_vec(2,  mk(1, 0, 4'd5, 32'h33, 2'b00, 0, 0),               1, 4'd4, 32'h22,       0, 0, 16'd2);
        set_vec(3,  idle(),                                            1, 4'd5, 32'h33,       0, 0, 16'd3);
        set_vec(4,  idle(),                                            0, 4'd5, 32'h33,       0, 0, 16'd3);
        set_vec(5,  mk(1, 1, 4'd7, 32'h0, 2'b00, 0, 0),                0, 4'd5, 32'h33,       0, 0, 16'd3);
        set_vec(6,  mk(1, 0, 4'd2, 32'h5, 2'b00, 0, 0),                0, 4'd5, 32'h33,       0, 0, 16'd3);
        set_vec(7,  idle(),                                            0, 4'd5, 32'h33,       0, 0, 16'd3);
        set_vec(8,  mk(0, 0, 4'd0, 32'h0, 2'b00, 1, 32'hDEADBEEF),     1, 4'd7, 32'hDEADBEEF, 0, 0, 16'd4);
        set_vec(9,  idle(),                                            1, 4'd2, 32'h5,        0, 0, 16'd5);
        set_vec(10, idle(),                                            0, 4'd2, 32'h5,        0, 0, 16'd5);
        set_vec(11, mk(1, 0, 4'd9, 32'hABCD0000, 2'b10, 0, 0),         0, 4'd2, 32'h5,        0, 0, 16'd5);
        set_vec(12, idle(),                                            1, 4'd9, 32'hABCD0000, 1, 0, 16'd6);
        set_vec(13, idle(),                                            0, 4'd9, 32'hABCD0000, 0, 0, 16'd6);
        set_vec(14, mk(1, 0, 4'd1, 32'h77, 2'b11, 0, 0),               0, 4'd9, 32'hABCD0000, 0, 0, 16'd6);
        set_vec(15, idle(),                                            1, 4'd1, 32'h77,       0, 0, 16'd7);
        set_vec(16, idle(),                                            0, 4'd1, 32'h77,       0, 0, 16'd7);

        rs = idle();
        rs.rst = 1'b1;
        cycle(rs);
        cycle(rs);
        check("reset wr", {31'd0, bus.wr}, 32'd0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].in);
            check($sformatf("vec%0d wr", i),   {31'd0, bus.wr},          {31'd0, tbl[i].wr});
            check($sformatf("vec%0d dst", i),  {28'd0, bus.wr_dst},      {28'd0, tbl[i].dst});
            check($sformatf("vec%0d data", i), bus.wr_data,              tbl[i].data);
            check($sformatf("vec%0d high", i), {31'd0, bus.high},        {31'd0, tbl[i].hi});
            check($sformatf("vec%0d low", i),  {31'd0, bus.low},         {31'd0, tbl[i].lo});
            check($sformatf("vec%0d cnt", i),  {16'd0, bus.retired_cnt}, {16'd0, tbl[i].cnt});
        end

        // Full queue: four loads without data, a fifth held off until one completes
        for (int i = 0; i < 4; i++) cycle(mk(1, 1, 4'(12 + i), 32'h0, 2'b00, 0, 0));
        check("full in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full stall",    {31'd0, bus.stall},    32'd1);
        cycle(mk(1, 1, 4'd1, 32'h0, 2'b00, 0, 0));
        check("full held in_ready", {31'd0, bus.in_ready}, 32'd0);
        cycle(mk(1, 1, 4'd1, 32'h0, 2'b00, 1, 32'h100));
        check("full pop in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("full pop dst",      {28'd0, bus.wr_dst},   32'd12);
        cycle(mk(1, 1, 4'd1, 32'h0, 2'b00, 0, 0));
        for (int i = 0; i < 4; i++) cycle(mk(0, 0, 4'd0, 32'h0, 2'b00, 1, 32'h101 + i));
        cycle(idle());
        check("drain last dst",  {28'd0, bus.wr_dst}, 32'd1);
        check("drain last data", bus.wr_data,         32'h104);

        // Early data captured behind an ALU head, then overflow of the hold register
        cycle(mk(1, 0, 4'd1, 32'h1, 2'b00, 0, 0));
        cycle(mk(1, 1, 4'd6, 32'h0, 2'b00, 1, 32'hCAFE0001));
        cycle(idle());
        check("early wr",   {31'd0, bus.wr},     32'd1);
        check("early dst",  {28'd0, bus.wr_dst}, 32'd6);
        check("early data", bus.wr_data,         32'hCAFE0001);
        cycle(mk(0, 0, 4'd0, 32'h0, 2'b00, 1, 32'h2));
        check("no ovf yet", {31'd0, bus.rdata_ovf}, 32'd0);
        cycle(mk(0, 0, 4'd0, 32'h0, 2'b00, 1, 32'h3));
        check("ovf set", {31'd0, bus.rdata_ovf}, 32'd1);
        cycle(idle());
        check("ovf sticky", {31'd0, bus.rdata_ovf}, 32'd1);
        cycle(mk(1, 1, 4'd8, 32'h0, 2'b00, 0, 0));
        cycle(idle());
        check("held data dst",  {28'd0, bus.wr_dst}, 32'd8);
        check("held data kept", bus.wr_data,         32'h2);

        // Reset with two loads pending
        cycle(mk(1, 1, 4'd10, 32'h0, 2'b00, 0, 0));
        cycle(mk(1, 1, 4'd11, 32'h0, 2'b00, 0, 0));
        cycle(rs);
        check("rst mid wr",       {31'd0, bus.wr},          32'd0);
        check("rst mid in_ready", {31'd0, bus.in_ready},    32'd1);
        check("rst mid cnt",      {16'd0, bus.retired_cnt}, 32'd0);
        cycle(mk(0, 0, 4'd0, 32'h0, 2'b00, 1, 32'h55));
        cycle(idle());
        check("rst stale data no wr", {31'd0, bus.wr}, 32'd0);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            in_t s;
            s.rst    = ($urandom_range(0, 199) == 0);
            s.v      = ($urandom_range(0, 3) != 0);
            s.reg_wr = ($urandom_range(0, 4) != 0);
            s.sel    = $urandom_range(0, 1);
            s.dst    = 4'($urandom_range(0, 15));
            s.res    = $urandom;
            s.half   = 2'($urandom_range(0, 3));
            s.mv     = ($urandom_range(0, 2) == 0);
            s.md     = $urandom;
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
